tap_route_ctrl: RTL and testbench



---
 rtl/tap_pkg.sv | 25 ++
 rtl/tap_fsm_next.sv | 33 +++
 rtl/tap_route_ctrl.sv | 38 +++
 tb/tb_tap_route_ctrl.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/tap_pkg.sv
// Shared TAP controller definitions: state encoding and reset state.
package tap_pkg;

    typedef enum logic [3:0] {
        StExit2Dr = 4'h0,
        StExit1Dr = 4'h1,
        StShiftDr = 4'h2,
        StPauseDr = 4'h3,
        StSelIr   = 4'h4,
        StUpdDr   = 4'h5,
        StCapDr   = 4'h6,
        StSelDr   = 4'h7,
        StExit2Ir = 4'h8,
        StExit1Ir = 4'h9,
        StShiftIr = 4'hA,
        StPauseIr = 4'hB,
        StRti     = 4'hC,
        StUpdIr   = 4'hD,
        StCapIr   = 4'hE,
        StTlr     = 4'hF
    } tap_state_t;

    localparam tap_state_t TAP_RESET_STATE = StTlr;

endpackage

// File: rtl/tap_fsm_next.sv
// Combinational next-state function of the 1149.1 TAP controller.
module tap_fsm_next
    import tap_pkg::*;
(
    input  tap_state_t state_i,
    input  logic       tms_i,
    output tap_state_t next_o
);

    always_comb begin
        next_o = state_i;
        unique case (state_i)
            StTlr:     next_o = tms_i ? StTlr     : StRti;
            StRti:     next_o = tms_i ? StSelDr   : StRti;
            StSelDr:   next_o = tms_i ? StSelIr   : StCapDr;
            StCapDr:   next_o = tms_i ? StExit1Dr : StShiftDr;
            StShiftDr: next_o = tms_i ? StExit1Dr : StShiftDr;
            StExit1Dr: next_o = tms_i ? StUpdDr   : StPauseDr;
            StPauseDr: next_o = tms_i ? StExit2Dr : StPauseDr;
            StExit2Dr: next_o = tms_i ? StUpdDr   : StShiftDr;
            StUpdDr:   next_o = tms_i ? StSelDr   : StRti;
            StSelIr:   next_o = tms_i ? StTlr     : StCapIr;
            StCapIr:   next_o = tms_i ? StExit1Ir : StShiftIr;
            StShiftIr: next_o = tms_i ? StExit1Ir : StShiftIr;
            StExit1Ir: next_o = tms_i ? StUpdIr   : StPauseIr;
            StPauseIr: next_o = tms_i ? StExit2Ir : StPauseIr;
            StExit2Ir: next_o = tms_i ? StUpdIr   : StShiftIr;
            StUpdIr:   next_o = tms_i ? StSelDr   : StRti;
            default:   next_o = StTlr;
        endcase
    end

endmodule

// File: rtl/tap_route_ctrl.sv
// TAP controller top: state register with synchronous reset, state code driven
// straight from the register onto the four observation pads.
module tap_route_ctrl
    import tap_pkg::*;
(
    input  logic GCLK_Pad,
    input  logic TRST_Pad,
    input  logic TMS_Pad,
    output logic state_obs0_Pad,
    output logic state_obs1_Pad,
    output logic state_obs2_Pad,
    output logic state_obs3_Pad
);

    tap_state_t state_q;
    tap_state_t state_d;

    tap_fsm_next u_fsm_next (
        .state_i (state_q),
        .tms_i   (TMS_Pad),
        .next_o  (state_d)
    );

    // Reset takes priority over TMS on the same edge.
    always_ff @(posedge GCLK_Pad) begin
        if (!TRST_Pad) begin
            state_q <= TAP_RESET_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_obs0_Pad = state_q[0];
    assign state_obs1_Pad = state_q[1];
    assign state_obs2_Pad = state_q[2];
    assign state_obs3_Pad = state_q[3];

endmodule

// File: tb/tb_tap_route_ctrl.sv
// Self-checking bench for tap_route_ctrl: expected codes queued as each edge is
// driven, popped and compared just after that edge.
module tb_tap_route_ctrl;

    logic clk;
    logic trst;
    logic tms;
    logic obs0, obs1, obs2, obs3;
    logic [3:0] obs;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];

    // Independent transition tables indexed by state code.
    logic [3:0] nx0 [16] = '{4'h2, 4'h3, 4'h2, 4'h3, 4'hE, 4'hC, 4'h2, 4'h6,
                             4'hA, 4'hB, 4'hA, 4'hB, 4'hC, 4'hC, 4'hA, 4'hC};
    logic [3:0] nx1 [16] = '{4'h5, 4'h5, 4'h1, 4'h0, 4'hF, 4'h7, 4'h1, 4'h4,
                             4'hD, 4'hD, 4'h9, 4'h8, 4'h7, 4'h7, 4'h9, 4'hF};

    tap_route_ctrl dut (
        .GCLK_Pad       (clk),
        .TRST_Pad       (trst),
        .TMS_Pad        (tms),
        .state_obs0_Pad (obs0),
        .state_obs1_Pad (obs1),
        .state_obs2_Pad (obs2),
        .state_obs3_Pad (obs3)
    );

    assign obs = {obs3, obs2, obs1, obs0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] model_next(input logic [3:0] s, input logic t);
        return t ? nx1[s] : nx0[s];
    endfunction

    task automatic step(input logic r, input logic t, input logic [3:0] exp, input string name);
        logic [3:0] e;
        trst = r;
        tms  = t;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, obs=%h", name, obs);
        end else begin
            e = exp_q.pop_front();
            if (obs !== e) begin
                errors++;
                $display("FAIL %s: obs=%h expected=%h", name, obs, e);
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 20; i++) step(1'b0, 1'($urandom_range(0, 1)), 4'hF, "reset_hold");
        step(1'b1, 1'b0, 4'hC, "reset_release");
    endtask

    task automatic test_dr_path();
        logic       t [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [3:0] e [9] = '{4'h7, 4'h6, 4'h2, 4'h2, 4'h1, 4'h3, 4'h0, 4'h5, 4'hC};
        for (int i = 0; i < 9; i++) step(1'b1, t[i], e[i], "dr_path");
    endtask

    task automatic test_ir_path();
        logic       t [10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [3:0] e [10] = '{4'h7, 4'h4, 4'hE, 4'hA, 4'h9, 4'hB, 4'h8, 4'hA, 4'h9, 4'hD};
        for (int i = 0; i < 10; i++) step(1'b1, t[i], e[i], "ir_path");
        step(1'b1, 1'b1, 4'h7, "ir_upd_to_seldr");
    endtask

    task automatic test_reset_mid_shift();
        step(1'b0, 1'b0, 4'hF, "shift_prep_rst");
        step(1'b1, 1'b0, 4'hC, "shift_prep_rti");
        step(1'b1, 1'b1, 4'h7, "shift_prep_seldr");
        step(1'b1, 1'b0, 4'h6, "shift_prep_capdr");
        step(1'b1, 1'b0, 4'h2, "shift_prep_shiftdr");
        step(1'b0, 1'b1, 4'hF, "reset_over_tms");
    endtask

    task automatic test_five_ones();
        logic [3:0] m;
        logic       t;
        int         n;
        for (int s = 0; s < 16; s++) begin
            step(1'b0, 1'b0, 4'hF, "sweep_reset");
            m = 4'hF;
            n = 0;
            while (m != 4'(s) && n < 200) begin
                t = 1'($urandom_range(0, 1));
                m = model_next(m, t);
                step(1'b1, t, m, "sweep_walk");
                n++;
            end
            checks++;
            if (m != 4'(s)) begin
                errors++;
                $display("FAIL sweep_reach: model=%h target=%h", m, 4'(s));
            end
            for (int k = 0; k < 4; k++) begin
                m = model_next(m, 1'b1);
                step(1'b1, 1'b1, m, "sweep_ones");
            end
            step(1'b1, 1'b1, 4'hF, "sweep_fifth_one");
            step(1'b1, 1'b1, 4'hF, "sweep_tlr_hold");
            step(1'b1, 1'b0, 4'hC, "sweep_tlr_exit");
        end
    endtask

    task automatic test_rti_hold();
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 4'hC, "rti_hold");
        step(1'b1, 1'b1, 4'h7, "rti_seldr");
        step(1'b1, 1'b1, 4'h4, "rti_selir");
        step(1'b1, 1'b1, 4'hF, "rti_tlr");
    endtask

    initial begin
        trst = 1'b1;
        tms  = 1'b0;
        #2;
        test_reset();
        test_dr_path();
        test_ir_path();
        test_reset_mid_shift();
        test_five_ones();
        step(1'b1, 1'b0, 4'hC, "rti_enter");
        test_rti_hold();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: left=%0d expected=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
